instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Serial program loader: receives a UART 8N1 byte stream from the host and writes 16-bit words
//  into the writable instruction memory, i.e. the write side of the port the PC-addressed fetch reads.
//  Holds the processor in reset (cpu_hold) until a complete, checksum-verified image is written.
// PARAMETERS
//  CLKS_PER_BIT    868        clk cycles per UART bit (100 MHz / 115200)
//  SYNC_BYTE       8'hA5      frame start marker
//  TIMEOUT_CYCLES  10_000_000 max idle clk cycles between bytes inside a frame
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-low reset (rst=0 resets)
//  uart_rx    in   1   serial input, idle high, asynchronous to clk
//  mem_we     out  1   instruction memory write strobe, one-cycle pulse
//  mem_addr   out  8   instruction memory write address
//  mem_wdata  out  16  instruction word to write
//  cpu_hold   out  1   1 = keep PC/regfile in reset
//  load_done  out  1   image loaded and checksum matched
//  load_err   out  1   checksum, framing or timeout failure
// BEHAVIOUR
//  Reset: mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, FSM=IDLE, rx sync FFs=1.
//  RX: uart_rx passes through 2-FF synchronizer. In RX_IDLE, a falling edge arms the start check.
//   - At CLKS_PER_BIT/2, sample must be 0; otherwise treat as glitch and return to RX_IDLE with no byte.
//   - 8 data bits are sampled LSB first, each at CLKS_PER_BIT spacing from the start-bit centre.
//   - Stop bit: 1 -> rx_valid pulses 1 cycle with rx_byte. 0 -> rx_ferr pulses and the byte is discarded.
//  Frame: SYNC_BYTE, LEN (0 means 256 words), LEN x {hi byte, lo byte}, CHK (XOR of all 2*LEN data bytes).
//  Loader FSM advances only on rx_valid:
//   IDLE: byte==SYNC_BYTE -> LEN; any other byte is ignored.
//   LEN : remaining<=(byte==0)?256:byte (9-bit); addr<=0; chk<=0; load_done<=0; load_err<=0; cpu_hold<=1 -> HI.
//   HI  : mem_wdata[15:8]<=byte; chk^=byte -> LO.
//   LO  : mem_wdata[7:0]<=byte; chk^=byte; mem_we=1 in the next cycle with mem_addr = current address.
//         The cycle after the write, mem_addr increments (wraps 8'hFF->8'h00 only after the final word).
//         Then remaining-=1; remaining==0 -> CHK, else HI.
//   CHK : byte==chk -> DONE (load_done=1, cpu_hold=0); else ERR (load_err=1, cpu_hold stays 1).
//   DONE/ERR: hold outputs. SYNC_BYTE -> LEN (reload, cpu_hold re-asserted at once); other bytes ignored.
//  Errors: rx_ferr while in LEN/HI/LO/CHK -> ERR. An idle counter runs in LEN/HI/LO/CHK and clears on
//   each byte; reaching TIMEOUT_CYCLES -> ERR. If rx_valid and timeout coincide, the byte wins.
//  Words already written before an error are not rolled back; cpu_hold keeps the CPU stopped.
//  Latency: mem_we asserts 1 clk after the rx_valid of the lo byte. load_done asserts 1 clk after CHK rx_valid.
//  Async reset mid-frame aborts immediately to reset values; there is no partial-write recovery.
// TESTING
//  1 A5,02,12,34,AB,CD,40 -> writes addr0=16'h1234, addr1=16'hABCD; load_done=1, cpu_hold=0, load_err=0.
//  2 Same frame with CHK=41 -> both writes occur; load_err=1, load_done=0, cpu_hold=1.
//  3 A5,00, 512 data bytes, correct CHK -> exactly 256 mem_we pulses, addr 00..FF; load_done=1.
//  4 Stop bit forced 0 on 3rd data byte -> FSM=ERR, load_err=1. Next full valid frame -> load_done=1, load_err=0.
//  5 uart_rx low pulse of CLKS_PER_BIT/4 -> no rx_valid, no state change. Byte 0x55 before A5 -> ignored.
//  6 rst=0 after the hi byte of word 1 -> all outputs at reset values. No further byte for
//    TIMEOUT_CYCLES mid-frame -> load_err=1.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Instruction-memory write port driven by the serial program loader.
interface instr_mem_loader_if;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/instr_mem_loader.sv
// Serial program loader: UART 8N1 receiver feeding a framed image writer that
// fills instruction memory and releases the CPU once the checksum matches.
module instr_mem_loader #(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rx,
    instr_mem_loader_if.master         mem,
    output logic                       cpu_hold,
    output logic                       load_done,
    output logic                       load_err
);

    localparam int unsigned BIT_CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TO_CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BIT_CNT_W-1:0] HALF_M1 = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] FULL_M1 = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_CNT_W-1:0]  TO_M1   = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_LEN, L_HI, L_LO, L_CHK, L_DONE, L_ERR} ld_state_t;

    // ---------------- receiver ----------------
    logic                 rx_meta, rx_sync, rx_prev;
    rx_state_t            rx_state, rx_state_d;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [2:0]           bit_idx, bit_idx_d;
    logic [7:0]           rx_byte, rx_byte_d;
    logic                 rx_valid, rx_valid_d;
    logic                 rx_ferr, rx_ferr_d;

    // Two-flop synchronizer plus previous-sample register for start-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            bit_cnt  <= bit_cnt_d;
            bit_idx  <= bit_idx_d;
            rx_byte  <= rx_byte_d;
            rx_valid <= rx_valid_d;
            rx_ferr  <= rx_ferr_d;
        end
    end

    // Receiver next state: centre-sample start, 8 data bits LSB first, then stop
    always_comb begin
        rx_state_d = rx_state;
        bit_cnt_d  = bit_cnt;
        bit_idx_d  = bit_idx;
        rx_byte_d  = rx_byte;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_d = RX_START;
                    bit_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (bit_cnt == HALF_M1) begin
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    // A line already high again at mid-bit was only a glitch
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_d = '0;
                    rx_byte_d = {rx_sync, rx_byte[7:1]};
                    if (bit_idx == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_d  = '0;
                    rx_valid_d = rx_sync;
                    rx_ferr_d  = !rx_sync;
                    rx_state_d = RX_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- frame loader ----------------
    ld_state_t           ld_state, ld_state_d;
    logic [8:0]          remaining, remaining_d;
    logic [7:0]          chk, chk_d;
    logic [TO_CNT_W-1:0] idle_cnt, idle_cnt_d;
    logic                we_q, we_d;
    logic [7:0]          addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                hold_d, done_d, err_d;
    logic                in_frame;

    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Loader state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_state  <= L_IDLE;
            remaining <= '0;
            chk       <= '0;
            idle_cnt  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            ld_state  <= ld_state_d;
            remaining <= remaining_d;
            chk       <= chk_d;
            idle_cnt  <= idle_cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_hold  <= hold_d;
            load_done <= done_d;
            load_err  <= err_d;
        end
    end

    assign in_frame = (ld_state == L_LEN) || (ld_state == L_HI) ||
                      (ld_state == L_LO)  || (ld_state == L_CHK);

    // Loader next state: frame parsing, word writes, checksum, error capture
    always_comb begin
        ld_state_d  = ld_state;
        remaining_d = remaining;
        chk_d       = chk;
        idle_cnt_d  = '0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hold_d      = cpu_hold;
        done_d      = load_done;
        err_d       = load_err;

        // Address advances the cycle after each write strobe
        if (we_q) begin
            addr_d = addr_q + 8'd1;
        end

        case (ld_state)
            L_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    ld_state_d = L_LEN;
                end
            end
            L_LEN: begin
                if (rx_valid) begin
                    remaining_d = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    addr_d      = '0;
                    chk_d       = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    hold_d      = 1'b1;
                    ld_state_d  = L_HI;
                end
            end
            L_HI: begin
                if (rx_valid) begin
                    wdata_d[15:8] = rx_byte;
                    chk_d         = chk ^ rx_byte;
                    ld_state_d    = L_LO;
                end
            end
            L_LO: begin
                if (rx_valid) begin
                    wdata_d[7:0] = rx_byte;
                    chk_d        = chk ^ rx_byte;
                    we_d         = 1'b1;
                    remaining_d  = remaining - 9'd1;
                    ld_state_d   = (remaining == 9'd1) ? L_CHK : L_HI;
                end
            end
            L_CHK: begin
                if (rx_valid) begin
                    if (rx_byte == chk) begin
                        ld_state_d = L_DONE;
                        done_d     = 1'b1;
                        hold_d     = 1'b0;
                    end else begin
                        ld_state_d = L_ERR;
                        err_d      = 1'b1;
                        hold_d     = 1'b1;
                    end
                end
            end
            L_DONE, L_ERR: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    ld_state_d = L_LEN;
                    hold_d     = 1'b1;
                end
            end
            default: ld_state_d = L_IDLE;
        endcase

        // Framing error or inter-byte timeout aborts a frame; a valid byte wins
        if (in_frame && !rx_valid) begin
            idle_cnt_d = idle_cnt + 1'b1;
            if (rx_ferr || idle_cnt == TO_M1) begin
                ld_state_d = L_ERR;
                err_d      = 1'b1;
                done_d     = 1'b0;
                hold_d     = 1'b1;
                idle_cnt_d = '0;
            end
        end
    end

endmodule
